// File: rtl/twos_comp_decoder_if.sv
// Word-in / result-out handshake bundle for the bit-serial two's-complement decoder.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1;
// a source holds valid and its payload stable until that edge, and ready never waits on valid.
interface twos_comp_decoder_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_sign;
   logic [WIDTH-1:0] out_mag;
   logic             busy;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sign, out_mag, busy
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sign, out_mag, busy
   );
endinterface

// File: rtl/twos_comp_decoder.sv
// Bit-serial two's-complement to sign/magnitude decoder: one input bit per CONV cycle, LSB first.
// The result registers only change on the final CONV edge, so the last result stays visible between words.
module twos_comp_decoder #(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   twos_comp_decoder_if.slave  bus,
   output logic [1:0]          dbg_state
);
   localparam int IW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] acc;
   logic [IW-1:0]    idx;
   logic             sign_q;
   logic             seen_one;
   logic             out_valid_q;
   logic             out_sign_q;
   logic [WIDTH-1:0] out_mag_q;
   logic             cur_bit;
   logic             res_bit;

   // Negation rule: copy bits up to and including the first 1, invert everything above it.
   always_comb begin
      cur_bit = shreg[0];
      res_bit = (sign_q && seen_one) ? ~cur_bit : cur_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         shreg       <= '0;
         acc         <= '0;
         idx         <= '0;
         sign_q      <= 1'b0;
         seen_one    <= 1'b0;
         out_valid_q <= 1'b0;
         out_sign_q  <= 1'b0;
         out_mag_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  shreg    <= bus.in_data;
                  sign_q   <= bus.in_data[WIDTH-1];
                  acc      <= '0;
                  idx      <= '0;
                  seen_one <= 1'b0;
                  state    <= CONV;
               end
            end
            CONV: begin
               shreg <= shreg >> 1;
               acc   <= {res_bit, acc[WIDTH-1:1]};
               idx   <= idx + IW'(1);
               if (cur_bit) begin
                  seen_one <= 1'b1;
               end
               if (idx == IW'(WIDTH - 1)) begin
                  out_mag_q   <= {res_bit, acc[WIDTH-1:1]};
                  out_sign_q  <= sign_q;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_sign  = out_sign_q;
   assign bus.out_mag   = out_mag_q;
   assign dbg_state     = state;
endmodule

// File: tb/tb_twos_comp_decoder.sv
// Bench for twos_comp_decoder: directed timing, backpressure, reset abort and an exhaustive sweep,
// with results checked against an arithmetic |v| model through an expected queue.
module tb_twos_comp_decoder;
   localparam int W = 4;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;
   bit         rdy_rand;
   int         n_tests;
   int         n_fail;
   int         n_results;
   logic [W:0] exp_q[$];

   twos_comp_decoder_if #(.WIDTH(W)) bus ();

   twos_comp_decoder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] v);
      logic         s;
      logic [W-1:0] m;
      s = v[W-1];
      m = s ? (~v + W'(1)) : v;
      return {s, m};
   endfunction

   // driver tasks
   task automatic wait_in_ready();
      int t;
      t = 0;
      while (!bus.in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
   endtask

   // Returns #1 after the accept edge.
   task automatic drive_word(input logic [W-1:0] v, input bit push);
      wait_in_ready();
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      if (push) exp_q.push_back(model(v));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out_valid();
      int t;
      t = 0;
      while (!bus.out_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!bus.out_valid) check("out_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   always @(posedge clk) begin
      #1;
      if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
   end

   // scoreboard: a transfer completes on the next rising edge
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         n_results++;
         if (exp_q.size() == 0) begin
            check("unexpected_result", {27'd0, bus.out_sign, bus.out_mag}, 32'h0);
         end else begin
            check("result", {27'd0, bus.out_sign, bus.out_mag}, {27'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      int base;
      n_tests = 0; n_fail = 0; n_results = 0;
      rdy_rand      = 1'b0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 4'b0101;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_sign", 32'(bus.out_sign), 32'd0);
      check("rst_out_mag", 32'(bus.out_mag), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // 0101 with out_ready high: valid at k=4, busy for k=0..4
      bus.out_ready = 1'b1;
      drive_word(4'b0101, 1'b1);
      for (int k = 0; k <= 5; k++) begin
         check($sformatf("lat_busy_k%0d", k), 32'(bus.busy), (k <= 4) ? 32'd1 : 32'd0);
         check($sformatf("lat_valid_k%0d", k), 32'(bus.out_valid), (k == 4) ? 32'd1 : 32'd0);
         if (k < 5) begin
            @(posedge clk); #1;
         end
      end
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);
      check("retain_mag", 32'(bus.out_mag), 32'h5);
      check("retain_sign", 32'(bus.out_sign), 32'd0);

      drive_word(4'b1011, 1'b1);
      drive_word(4'b1111, 1'b1);
      drive_word(4'b1000, 1'b1);
      drive_word(4'b0000, 1'b1);
      drain();

      // backpressure with input changes during CONV/DONE
      bus.out_ready = 1'b0;
      drive_word(4'b1011, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'b0111;
      wait_out_valid();
      for (int k = 0; k < 3; k++) begin
         check("bp_valid", 32'(bus.out_valid), 32'd1);
         check("bp_sign", 32'(bus.out_sign), 32'd1);
         check("bp_mag", 32'(bus.out_mag), 32'h5);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_idle", 32'(bus.in_ready), 32'd1);
      check("bp_release_valid", 32'(bus.out_valid), 32'd0);
      drain();

      // reset during the second CONV cycle aborts the word
      drive_word(4'b0101, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_state", 32'(dbg_state), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         check("abort_no_valid", 32'(bus.out_valid), 32'd0);
      end
      drive_word(4'b1110, 1'b1);
      drain();

      // exhaustive sweep with random out_ready
      base     = n_results;
      rdy_rand = 1'b1;
      for (int v = 0; v < (1 << W); v++) begin
         drive_word(W'(v), 1'b1);
      end
      drain();
      rdy_rand = 1'b0;
      check("sweep_count", 32'(n_results - base), 32'(1 << W));

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/twos_comp_decoder.md
TWOS_COMP_DECODER -- requirements
Module: twos_comp_decoder

Interface
REQ-001 Parameter: WIDTH, default 4, word width in bits; the legal range SHALL be 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_data holds a word to decode.
REQ-005 in_ready  output  1  the block can accept a word; high only in IDLE.
REQ-006 in_data  input  WIDTH  two's-complement signed input word.
REQ-007 out_valid  output  1  out_sign and out_mag hold a decoded result.
REQ-008 out_ready  input  1  the consumer accepts the result.
REQ-009 out_sign  output  1  sign of the decoded word (1 = negative).
REQ-010 out_mag  output  WIDTH  unsigned magnitude |in_data|.
REQ-011 busy  output  1  high in CONV or DONE.

Function
REQ-012 The block SHALL implement a state machine with three states: IDLE, CONV and DONE.
REQ-013 in_ready SHALL be driven combinationally as (state == IDLE); busy SHALL be its complement.
REQ-014 Accept edge, IDLE with in_valid=1: the block SHALL latch in_data into a shift register, SHALL latch sign = in_data[WIDTH-1], SHALL clear the bit index and the "seen-one" flag, and SHALL go to CONV.
REQ-015 IDLE with in_valid=0: the block SHALL stay in IDLE with no state change.
REQ-016 CONV: the block SHALL process one bit per cycle, LSB first; there SHALL be exactly WIDTH CONV cycles.
REQ-017 Bit rule when sign=0: the output bit SHALL equal the input bit.
REQ-018 Bit rule when sign=1: the output bit SHALL be (seen_one ? ~bit : bit), and seen_one SHALL be set after any processed bit equal to 1.
REQ-019 The result bits SHALL shift into the magnitude register so that, after WIDTH CONV cycles, out_mag[i] equals the result bit for input bit i.
REQ-020 On the edge that processes bit WIDTH-1, the block SHALL go to DONE and set out_valid=1; out_valid therefore rises exactly WIDTH edges after the accept edge.
REQ-021 DONE: out_valid, out_sign and out_mag SHALL hold stable until out_ready=1.
REQ-022 On the edge with out_valid=1 and out_ready=1, the block SHALL go to IDLE and clear out_valid; no new word SHALL be accepted on that edge.
REQ-023 Throughput SHALL be at most one word per WIDTH+2 cycles when out_ready is held high.
REQ-024 in_valid and in_data SHALL be ignored outside IDLE; input changes during CONV or DONE SHALL NOT affect the result.
REQ-025 Zero input: the result SHALL be out_sign=0 and out_mag=0, never a negative zero.
REQ-026 Most-negative input -2^(WIDTH-1): the result SHALL be out_sign=1 and out_mag=2^(WIDTH-1), i.e. MSB only set, with no overflow flag.
REQ-027 out_sign SHALL be driven from the sign latched at accept; between results out_sign and out_mag SHALL retain the last result.
REQ-028 If out_ready is high before out_valid rises, the handshake SHALL complete on the first DONE edge.

Reset
REQ-029 While rst_n=0: state SHALL be IDLE, out_valid=0, out_sign=0, out_mag=0, busy=0, and the internal shift register, bit index and seen_one SHALL be 0.
REQ-030 While rst_n=0, in_ready SHALL be 1 (IDLE); no accept SHALL occur while rst_n=0.
REQ-031 Reset asserted mid-CONV or mid-DONE SHALL abort the in-flight word immediately; no out_valid SHALL be produced for it.
REQ-032 The first accept after reset SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-033 WIDTH=4, in_data=4'b0101, out_ready=1 -> out_valid rises 4 edges after accept; out_sign=0, out_mag=4'b0101; handshake on the next edge; busy spans 5 cycles.
REQ-034 in_data=4'b1011 (-5) -> out_sign=1, out_mag=4'b0101; in_data=4'b1111 (-1) -> out_sign=1, out_mag=4'b0001.
REQ-035 in_data=4'b1000 -> out_sign=1, out_mag=4'b1000; in_data=4'b0000 -> out_sign=0, out_mag=4'b0000.
REQ-036 Backpressure: out_ready=0 for 3 cycles in DONE -> outputs stable and in_ready=0; in_data changed to 4'b0111 during CONV and DONE -> result unchanged; release out_ready -> return to IDLE.
REQ-037 rst_n pulsed low during the 2nd CONV cycle -> out_valid never asserts for that word; the next word 4'b1110 decodes to sign=1, mag=4'b0010.
REQ-038 Exhaustive sweep of all 16 codes (WIDTH=4) with random out_ready -> every result matches |v| with sign=(v<0); 2^WIDTH results, no drops, no duplicates.
